// File: rtl/audio_play_ctrl.sv
// Audio SRAM record/playback sequencer: one SRAM access per codec sample tick,
// with playback speed (fast skip / slow hold with interpolation phase) and pause.
module audio_play_ctrl #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned MAX_ADDR = 1048575
) (
  input  logic              CLK50,
  input  logic              RST,
  input  logic              key_record,
  input  logic              key_play,
  input  logic              key_pause,
  input  logic              key_stop,
  input  logic [1:0]        speed_mode,
  input  logic [2:0]        ratio_m1,
  input  logic              sample_tick,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_req,
  output logic [2:0]        interp_phase,
  output logic              mute,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              overrun
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RECORD     = 3'd1,
    S_PLAY       = 3'd2,
    S_PAUSE_REC  = 3'd3,
    S_PAUSE_PLAY = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic               req_q, req_n, we_q, we_n;
  logic [2:0]         phase_q, phase_n;
  logic [LEN_W-1:0]   rec_len_q, rec_len_n;
  logic               overrun_q, overrun_n;
  logic               mute_q, mute_n;
  logic               stop_pend_q, stop_pend_n;
  logic [1:0]         mode_q, mode_n;
  logic [2:0]         ratio_q, ratio_n;

  logic               ack_ok, to_idle, clr_pos, keys_ok, slow, fast;
  logic [LEN_W-1:0]   addr_ext, step, play_next;

  // State and datapath registers
  always_ff @(posedge CLK50) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      phase_q     <= 3'd0;
      rec_len_q   <= '0;
      overrun_q   <= 1'b0;
      mute_q      <= 1'b1;
      stop_pend_q <= 1'b0;
      mode_q      <= 2'd0;
      ratio_q     <= 3'd0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      req_q       <= req_n;
      we_q        <= we_n;
      phase_q     <= phase_n;
      rec_len_q   <= rec_len_n;
      overrun_q   <= overrun_n;
      mute_q      <= mute_n;
      stop_pend_q <= stop_pend_n;
      mode_q      <= mode_n;
      ratio_q     <= ratio_n;
    end
  end

  // Next-state: ack completion first, then keys, then sample ticks
  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    req_n       = req_q;
    we_n        = we_q;
    phase_n     = phase_q;
    rec_len_n   = rec_len_q;
    overrun_n   = overrun_q;
    stop_pend_n = stop_pend_q;
    mode_n      = mode_q;
    ratio_n     = ratio_q;
    to_idle     = 1'b0;
    clr_pos     = 1'b0;
    slow        = (mode_q == 2'd2);
    fast        = (mode_q == 2'd1);
    ack_ok      = mem_ack && req_q;
    keys_ok     = !stop_pend_q;
    addr_ext    = {1'b0, addr_q};
    step        = fast ? (LEN_W'(ratio_q) + LEN_W'(1)) : LEN_W'(1);
    play_next   = addr_ext + step;

    if (ack_ok) begin
      req_n = 1'b0;
      we_n  = 1'b0;
      if (state_q == S_RECORD || state_q == S_PAUSE_REC) begin
        rec_len_n = addr_ext + LEN_W'(1);
        if (addr_q == ADDR_W'(MAX_ADDR)) to_idle = 1'b1;
        else addr_n = addr_q + ADDR_W'(1);
      end else if (state_q == S_PLAY || state_q == S_PAUSE_PLAY) begin
        if (play_next >= rec_len_q) begin
          to_idle = 1'b1;
          clr_pos = 1'b1;
        end else begin
          addr_n = play_next[ADDR_W-1:0];
        end
      end
      if (stop_pend_q) begin
        to_idle = 1'b1;
        clr_pos = 1'b1;
      end
    end

    if (to_idle) begin
      state_n     = S_IDLE;
      stop_pend_n = 1'b0;
      if (clr_pos) begin
        addr_n  = '0;
        phase_n = 3'd0;
      end
    end else if (key_stop && keys_ok) begin
      // A request still outstanding after this cycle defers the stop to its ack
      if (req_q && !ack_ok) begin
        stop_pend_n = 1'b1;
      end else begin
        state_n = S_IDLE;
        addr_n  = '0;
        phase_n = 3'd0;
      end
    end else if (key_pause && keys_ok && state_q != S_IDLE) begin
      case (state_q)
        S_RECORD:    state_n = S_PAUSE_REC;
        S_PLAY:      state_n = S_PAUSE_PLAY;
        S_PAUSE_REC: state_n = S_RECORD;
        default: begin
          state_n = S_PLAY;
          mode_n  = speed_mode;
          ratio_n = ratio_m1;
          if (speed_mode != 2'd2) phase_n = 3'd0;
        end
      endcase
    end else if (key_record && keys_ok && state_q == S_IDLE) begin
      state_n   = S_RECORD;
      addr_n    = '0;
      phase_n   = 3'd0;
      rec_len_n = '0;
      overrun_n = 1'b0;
    end else if (key_play && keys_ok &&
                 ((state_q == S_IDLE && rec_len_q != '0) || state_q == S_PAUSE_PLAY)) begin
      state_n = S_PLAY;
      mode_n  = speed_mode;
      ratio_n = ratio_m1;
      if (state_q == S_IDLE) begin
        addr_n    = '0;
        phase_n   = 3'd0;
        overrun_n = 1'b0;
      end else if (speed_mode != 2'd2) begin
        phase_n = 3'd0;
      end
    end else if (sample_tick && (state_q == S_RECORD || state_q == S_PLAY)) begin
      if (req_q) begin
        overrun_n = 1'b1;
      end else if (state_q == S_RECORD) begin
        req_n = 1'b1;
        we_n  = 1'b1;
      end else if (slow) begin
        if (phase_q == 3'd0) begin
          req_n = 1'b1;
          we_n  = 1'b0;
        end
        phase_n = (phase_q == ratio_q) ? 3'd0 : phase_q + 3'd1;
      end else begin
        req_n = 1'b1;
        we_n  = 1'b0;
      end
    end

    mute_n = (state_n != S_PLAY);
  end

  assign mem_addr     = addr_q;
  assign mem_we       = we_q;
  assign mem_req      = req_q;
  assign interp_phase = phase_q;
  assign mute         = mute_q;
  assign state        = state_q;
  assign rec_len      = rec_len_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Directed bench for audio_play_ctrl with MAX_ADDR=15; expected values hand-computed.
module tb_audio_play_ctrl;

  logic        CLK50 = 1'b0;
  logic        RST = 1'b1;
  logic        key_record = 1'b0, key_play = 1'b0, key_pause = 1'b0, key_stop = 1'b0;
  logic [1:0]  speed_mode = 2'd0;
  logic [2:0]  ratio_m1 = 3'd0;
  logic        sample_tick = 1'b0, mem_ack = 1'b0;
  logic [19:0] mem_addr;
  logic        mem_we, mem_req, mute, overrun;
  logic [2:0]  interp_phase, state;
  logic [20:0] rec_len;

  int total = 0;
  int bad = 0;

  audio_play_ctrl #(.ADDR_W(20), .MAX_ADDR(15)) dut (
    .CLK50(CLK50), .RST(RST),
    .key_record(key_record), .key_play(key_play), .key_pause(key_pause), .key_stop(key_stop),
    .speed_mode(speed_mode), .ratio_m1(ratio_m1),
    .sample_tick(sample_tick), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_req(mem_req),
    .interp_phase(interp_phase), .mute(mute), .state(state),
    .rec_len(rec_len), .overrun(overrun)
  );

  always #10 CLK50 = ~CLK50;

  task automatic cyc();
    @(posedge CLK50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample tick; if a request appears, ack it after 'gap' idle cycles
  task automatic access(input int gap, output logic got, output logic [19:0] a,
                        output logic we, output logic [2:0] ph);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    got = mem_req;
    a   = mem_addr;
    we  = mem_we;
    ph  = interp_phase;
    repeat (gap) cyc();
    if (got) begin
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
    end
    cyc();
  endtask

  initial begin
    logic        got, we;
    logic [19:0] a;
    logic [2:0]  ph;

    repeat (3) cyc();
    RST = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_phase", interp_phase, 0);
    chk("rst_mute", mute, 1);
    chk("rst_len", rec_len, 0);
    chk("rst_ovr", overrun, 0);

    // play with nothing recorded stays idle
    key_play = 1'b1; cyc(); key_play = 1'b0;
    chk("play_empty_state", state, 0);

    // record and play in the same cycle: record wins
    key_record = 1'b1; key_play = 1'b1; cyc(); key_record = 1'b0; key_play = 1'b0;
    chk("rec_state", state, 1);
    chk("rec_mute", mute, 1);
    for (int i = 0; i < 20; i++) begin
      access(1, got, a, we, ph);
      if (i < 16) begin
        chk("rec_req", got, 1);
        chk("rec_addr", a, i);
        chk("rec_we", we, 1);
      end else begin
        chk("rec_after_full_req", got, 0);
      end
      if (i == 15) chk("rec_full_state", state, 0);
    end
    chk("rec_len16", rec_len, 16);

    // normal playback
    speed_mode = 2'd0; ratio_m1 = 3'd0;
    key_play = 1'b1; cyc(); key_play = 1'b0;
    chk("play_state", state, 2);
    chk("play_mute", mute, 0);
    for (int i = 0; i < 16; i++) begin
      access(1, got, a, we, ph);
      chk("play_req", got, 1);
      chk("play_addr", a, i);
      chk("play_we", we, 0);
    end
    chk("play_end_state", state, 0);
    chk("play_end_mute", mute, 1);
    chk("play_end_addr", mem_addr, 0);

    // fast x3; speed changed after entry must not matter
    speed_mode = 2'd1; ratio_m1 = 3'd2;
    key_play = 1'b1; cyc(); key_play = 1'b0;
    speed_mode = 2'd0; ratio_m1 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      access(1, got, a, we, ph);
      chk("fast_addr", a, 3 * i);
      chk("fast_phase", ph, 0);
    end
    chk("fast_end_state", state, 0);

    // slow x4
    speed_mode = 2'd2; ratio_m1 = 3'd3;
    key_play = 1'b1; cyc(); key_play = 1'b0;
    speed_mode = 2'd0;
    for (int t = 0; t <= 60; t++) begin
      access(1, got, a, we, ph);
      chk("slow_phase", ph, (t + 1) % 4);
      if (t % 4 == 0) begin
        chk("slow_req", got, 1);
        chk("slow_addr", a, t / 4);
      end else begin
        chk("slow_noreq", got, 0);
      end
    end
    chk("slow_end_state", state, 0);
    chk("slow_end_phase", interp_phase, 0);
    for (int t = 61; t < 64; t++) begin
      access(1, got, a, we, ph);
      chk("slow_idle_noreq", got, 0);
    end

    // pause in slow x3 at address 5, phase 1
    speed_mode = 2'd2; ratio_m1 = 3'd2;
    key_play = 1'b1; cyc(); key_play = 1'b0;
    for (int t = 0; t <= 12; t++) access(1, got, a, we, ph);
    chk("pre_pause_addr", mem_addr, 5);
    chk("pre_pause_phase", interp_phase, 1);
    key_pause = 1'b1; cyc(); key_pause = 1'b0;
    chk("pause_state", state, 4);
    chk("pause_mute", mute, 1);
    for (int t = 0; t < 10; t++) begin
      access(1, got, a, we, ph);
      chk("pause_noreq", got, 0);
    end
    chk("pause_addr", mem_addr, 5);
    chk("pause_phase", interp_phase, 1);
    key_play = 1'b1; cyc(); key_play = 1'b0;
    chk("resume_state", state, 2);
    access(1, got, a, we, ph);
    chk("resume_t13_req", got, 0);
    chk("resume_t13_phase", ph, 2);
    access(1, got, a, we, ph);
    chk("resume_t14_phase", ph, 0);
    access(1, got, a, we, ph);
    chk("resume_t15_req", got, 1);
    chk("resume_t15_addr", a, 5);
    key_stop = 1'b1; cyc(); key_stop = 1'b0;
    chk("stop_play_state", state, 0);
    chk("stop_play_addr", mem_addr, 0);
    chk("stop_play_phase", interp_phase, 0);
    chk("stop_play_len", rec_len, 16);

    // stop + pause together while recording
    key_record = 1'b1; cyc(); key_record = 1'b0;
    for (int i = 0; i < 5; i++) access(1, got, a, we, ph);
    key_stop = 1'b1; key_pause = 1'b1; cyc(); key_stop = 1'b0; key_pause = 1'b0;
    chk("stoprec_state", state, 0);
    chk("stoprec_len", rec_len, 5);
    chk("stoprec_addr", mem_addr, 0);

    // overrun: second tick while request pending
    speed_mode = 2'd0;
    key_play = 1'b1; cyc(); key_play = 1'b0;
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("ovr_req1", mem_req, 1);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_req_held", mem_req, 1);
    chk("ovr_addr_held", mem_addr, 0);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("ovr_ack_req", mem_req, 0);
    chk("ovr_ack_addr", mem_addr, 1);
    key_stop = 1'b1; cyc(); key_stop = 1'b0;
    chk("ovr_sticky", overrun, 1);
    key_play = 1'b1; cyc(); key_play = 1'b0;
    chk("ovr_clear", overrun, 0);

    // stop with a pending request waits for the ack
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    key_stop = 1'b1; cyc(); key_stop = 1'b0;
    chk("stop_pend_state", state, 2);
    chk("stop_pend_req", mem_req, 1);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("stop_ack_state", state, 0);
    chk("stop_ack_addr", mem_addr, 0);

    // reset in the middle of an access; late ack ignored
    key_play = 1'b1; cyc(); key_play = 1'b0;
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("midrst_req_before", mem_req, 1);
    RST = 1'b1; cyc(); RST = 1'b0;
    chk("midrst_req", mem_req, 0);
    chk("midrst_state", state, 0);
    mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    chk("midrst_late_ack_len", rec_len, 0);
    chk("midrst_late_ack_addr", mem_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
